// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-wide data RAM with byte enables.
// Misaligned accesses are split into two word transactions; loads are assembled and extended.
module lsu_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wData,
  output logic [3:0]        mem_Byte_Enable,
  input  logic [DATA_W-1:0] mem_rData
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t              state, state_nxt;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   buf0, buf1;

  logic                illegal;
  logic [1:0]          off;
  logic [2:0]          nbytes;
  logic [2:0]          endb;
  logic                split;
  logic [7:0]          base_mask;
  logic [7:0]          mask8;
  logic [2*DATA_W-1:0] d64;
  logic [ADDR_W-1:0]   word;
  logic [DATA_W-1:0]   r32;
  logic [DATA_W-1:0]   load_data;

  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_we && req_funct3[2]);

  assign off  = addr_q[1:0];
  assign word = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    nbytes    = 3'd4;
    base_mask = 8'h0F;
    case (f3_q[1:0])
      2'b00:   begin nbytes = 3'd1; base_mask = 8'h01; end
      2'b01:   begin nbytes = 3'd2; base_mask = 8'h03; end
      default: begin nbytes = 3'd4; base_mask = 8'h0F; end
    endcase
  end

  // An access spills into the next word when its last byte lies beyond lane 3.
  assign endb  = {1'b0, off} + nbytes;
  assign split = (endb > 3'd4);
  assign mask8 = base_mask << off;
  assign d64   = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
  assign r32   = DATA_W'({buf1, buf0} >> {off, 3'b000});

  always_comb begin
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{24{r32[7]}}, r32[7:0]};
      3'b001:  load_data = {{16{r32[15]}}, r32[15:0]};
      3'b010:  load_data = r32;
      3'b100:  load_data = {24'b0, r32[7:0]};
      3'b101:  load_data = {16'b0, r32[15:0]};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= illegal;
        buf0    <= '0;
        buf1    <= '0;
      end
      if (state == ACC0 && !we_q) buf0 <= mem_rData;
      if (state == ACC1 && !we_q) buf1 <= mem_rData;
    end
  end

  // Write strobe is qualified by reset so an aborting edge never commits a RAM write.
  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wData       = '0;
    mem_Byte_Enable = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = illegal ? RESP : ACC0;
      end
      ACC0: begin
        mem_we          = we_q & reset;
        mem_addr        = word;
        mem_Byte_Enable = mask8[3:0];
        mem_wData       = d64[DATA_W-1:0];
        state_nxt       = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_we          = we_q & reset;
        mem_addr        = word + ADDR_W'(4);
        mem_Byte_Enable = mask8[7:4];
        mem_wData       = d64[2*DATA_W-1:DATA_W];
        state_nxt       = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = ((state == RESP) && !we_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: a 256-byte RAM behind the port and a byte-array
// reference model that applies the RV32I load/store rules directly.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wData;
  logic [3:0]  mem_Byte_Enable;
  logic [31:0] mem_rData;

  logic [31:0] ram [0:63];
  logic [7:0]  mb  [0:255];

  int total = 0;
  int bad   = 0;

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wData(mem_wData),
    .mem_Byte_Enable(mem_Byte_Enable), .mem_rData(mem_rData)
  );

  always #5 clk = ~clk;

  assign mem_rData = ram[mem_addr[7:2]];

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelWord(input int idx);
    return {mb[4*idx+3], mb[4*idx+2], mb[4*idx+1], mb[4*idx]};
  endfunction

  task automatic setWord(input logic [31:0] a, input logic [31:0] v);
    logic [7:0] ba;
    ram[a[7:2]] = v;
    for (int k = 0; k < 4; k++) begin
      ba = {a[7:2], 2'b00} + 8'(k);
      mb[ba] = v[8*k +: 8];
    end
  endtask

  // One full request; abortAt>0 pulls reset low in that cycle after acceptance.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int abortAt);
    bit          illegal, split;
    int          n, off, got, nacc, widx;
    logic [31:0] v, expRd, w0, w1;
    logic [31:0] accA [0:1];
    logic [3:0]  accBE [0:1];
    logic [3:0]  expBE0, expBE1;
    logic [7:0]  ba;

    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    n       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off     = int'(a[1:0]);
    split   = (off + n) > 4;
    w0      = {a[31:2], 2'b00};
    w1      = w0 + 32'd4;
    expBE0  = 4'b0;
    expBE1  = 4'b0;
    for (int b = 0; b < 4; b++) begin
      expBE0[b] = (b >= off) && (b < off + n);
      expBE1[b] = (b + 4 < off + n);
    end

    expRd = 32'h0;
    if (!we && !illegal) begin
      v = 32'h0;
      for (int k = 0; k < n; k++) begin
        ba = 8'(a + 32'(k));
        v  = v | (32'(mb[ba]) << (8 * k));
      end
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      expRd = v;
    end

    @(negedge clk); #1;
    checkOutput("readyIdle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;

    got = 0; nacc = 0;
    accA[0] = 32'hX; accA[1] = 32'hX; accBE[0] = 4'hX; accBE[1] = 4'hX;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (abortAt == c) begin reset = 1'b0; req_valid = 1'b0; end
      #1;
      if (mem_Byte_Enable != 4'b0 || mem_we) begin
        if (nacc < 2) begin accA[nacc] = mem_addr; accBE[nacc] = mem_Byte_Enable; end
        checkOutput("memWe", {31'b0, mem_we}, {31'b0, (abortAt == c) ? 1'b0 : we});
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_Byte_Enable[b]) ram[mem_addr[7:2]][8*b +: 8] = mem_wData[8*b +: 8];
        nacc++;
      end
      if (rsp_valid) begin got = c; break; end
      if (abortAt == c) break;
      // Busy-time requests must be ignored, so keep valid high with junk fields.
      req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end

    if (abortAt != 0) begin
      checkOutput("abortRspAtEdge", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk); reset = 1'b1; #1;
      checkOutput("abortNoRsp", {31'b0, rsp_valid}, 32'd0);
      checkOutput("abortReady", {31'b0, req_ready}, 32'd1);
      checkOutput("abortAddr0", accA[0], w0);
      for (int k = 0; k < n; k++)
        if (off + k < 4) begin
          ba = 8'(a + 32'(k));
          mb[ba] = wd[8*k +: 8];
        end
      widx = int'(w0[7:2]);
      checkOutput("abortWord0", ram[widx], modelWord(widx));
      widx = int'(w1[7:2]);
      checkOutput("abortWord1", ram[widx], modelWord(widx));
      return;
    end

    req_valid = 1'b0;
    if (got == 0) begin
      checkOutput("rspTimeout", 32'd0, 32'd1);
      return;
    end
    if (illegal) checkOutput("latencyErr", {31'b0, (got == 1 || got == 2)}, 32'd1);
    else         checkOutput("latency", 32'(got), split ? 32'd3 : 32'd2);
    checkOutput("rspRdata", rsp_rdata, expRd);
    checkOutput("rspErr", {31'b0, rsp_err}, {31'b0, illegal});
    checkOutput("accessCount", 32'(nacc), illegal ? 32'd0 : (split ? 32'd2 : 32'd1));
    checkOutput("respBusIdle", mem_addr | mem_wData | {27'b0, mem_we, mem_Byte_Enable}, 32'd0);
    if (!illegal) begin
      checkOutput("addr0", accA[0], w0);
      checkOutput("be0", {28'b0, accBE[0]}, {28'b0, expBE0});
      if (split) begin
        checkOutput("addr1", accA[1], w1);
        checkOutput("be1", {28'b0, accBE[1]}, {28'b0, expBE1});
      end
    end
    if (we && !illegal) begin
      for (int k = 0; k < n; k++) begin
        ba = 8'(a + 32'(k));
        mb[ba] = wd[8*k +: 8];
      end
      widx = int'(w0[7:2]);
      checkOutput("storeWord0", ram[widx], modelWord(widx));
      widx = int'(w1[7:2]);
      checkOutput("storeWord1", ram[widx], modelWord(widx));
    end
  endtask

  initial begin
    bit          rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    for (int i = 0; i < 64; i++) setWord(32'(4 * i), $urandom);

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("resetReady", {31'b0, req_ready}, 32'd1);
    checkOutput("resetRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("resetRdata", rsp_rdata, 32'd0);
    checkOutput("resetErr", {31'b0, rsp_err}, 32'd0);
    checkOutput("resetBus", mem_addr | mem_wData | {27'b0, mem_we, mem_Byte_Enable}, 32'd0);
    reset = 1'b1;

    setWord(32'h40, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0);
    applyStimulus(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0);
    applyStimulus(1'b1, 3'b010, 32'h0000_0102, 32'h1122_3344, 0);
    setWord(32'h20, 32'h8012_3456);
    setWord(32'h24, 32'h0000_00FF);
    applyStimulus(1'b0, 3'b001, 32'h0000_0023, 32'h0, 0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0023, 32'h0, 0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0050, 32'h0, 0);
    applyStimulus(1'b1, 3'b100, 32'h0000_0054, 32'h1234_5678, 0);
    applyStimulus(1'b1, 3'b010, 32'h0000_0102, 32'hCAFE_F00D, 2);
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0104, 32'h0, 0);
    applyStimulus(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h5566_7788, 0);
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 0);
    applyStimulus(1'b0, 3'b000, 32'h0000_0007, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      rwe   = 1'($urandom);
      rf3   = 3'($urandom_range(0, 7));
      raddr = $urandom;
      applyStimulus(rwe, rf3, raddr, $urandom, 0);
    end

    for (int i = 0; i < 64; i++) checkOutput("finalRam", ram[i], modelWord(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
